apb_i2c_regs: RTL and testbench

- APB3 slave register file and transmit sequencer sitting directly upstream of the I2C master controller.
- Software programs the target address and pushes data bytes into a TX FIFO, then kicks a transfer.
- The block presents one byte at a time to the controller (enable/slave_address/data_in/repeated_start_cond) and waits for a per-byte done pulse.
- It also captures read bytes returned by the controller side.

---
 rtl/apb_i2c_regs.sv | 245 ++++++++++++++++++++++++
 tb/tb_apb_i2c_regs.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_regs.sv
// APB3 register file and TX sequencer in front of the I2C master controller.
// Software fills a byte FIFO and kicks a transfer; bytes are handed over one per done pulse.
module apb_i2c_regs #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        i2c_enable,
    output logic [7:0]  i2c_slave_address,
    output logic [7:0]  i2c_data_in,
    output logic        i2c_repeated_start,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_rx_data,
    input  logic        i2c_rx_valid
);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_ADDR   = 3'd2;
    localparam logic [2:0] REG_TXDATA = 3'd3;
    localparam logic [2:0] REG_RXDATA = 3'd4;

    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER
    } state_t;

    state_t state;
    state_t state_next;

    logic             ctrl_en;
    logic             ctrl_rstart;
    logic             ovf;
    logic [7:0]       addr_reg;
    logic [7:0]       data_reg;
    logic [7:0]       rx_data_reg;
    logic             rx_flag;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic       access;
    logic [2:0] reg_sel;
    logic       decode_err;
    logic       wr_ok;
    logic       rd_ok;
    logic       wr_ctrl;
    logic       wr_status;
    logic       wr_addr;
    logic       rd_rxdata;
    logic       start_req;
    logic       flush_req;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       ovf_set;
    logic       fifo_full;
    logic       fifo_empty;
    logic       unused_bits;

    assign unused_bits = ^{paddr[1:0], pwdata[31:8]};

    assign access  = psel & penable;
    assign reg_sel = paddr[4:2];
    assign pready  = 1'b1;

    always_comb begin
        decode_err = 1'b1;
        case (reg_sel)
            REG_CTRL, REG_STATUS, REG_ADDR: decode_err = 1'b0;
            REG_TXDATA:                     decode_err = ~pwrite;
            REG_RXDATA:                     decode_err = pwrite;
            default:                        decode_err = 1'b1;
        endcase
    end

    assign wr_ok     = access & pwrite & ~decode_err;
    assign rd_ok     = access & ~pwrite & ~decode_err;
    assign wr_ctrl   = wr_ok & (reg_sel == REG_CTRL);
    assign wr_status = wr_ok & (reg_sel == REG_STATUS);
    assign wr_addr   = wr_ok & (reg_sel == REG_ADDR);
    assign push_req  = wr_ok & (reg_sel == REG_TXDATA);
    assign rd_rxdata = rd_ok & (reg_sel == REG_RXDATA);
    assign start_req = wr_ctrl & pwdata[1];
    assign flush_req = wr_ctrl & pwdata[3];
    assign pslverr   = access & decode_err;

    assign fifo_full  = (count == CNT_DEPTH);
    assign fifo_empty = (count == '0);
    assign pop        = (state == ST_LOAD);

    // A pop frees the slot a simultaneous push needs, so a full FIFO only overflows without one.
    assign push_ok = push_req & ~flush_req & (~fifo_full | pop);
    assign ovf_set = push_req & ~flush_req & fifo_full & ~pop;

    always_comb begin
        count_next = count;
        if (flush_req) begin
            count_next = '0;
        end else if (push_ok && !pop) begin
            count_next = count + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= pwdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // The byte in flight lives outside the FIFO, so a flush never disturbs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
        end else if (pop) begin
            data_reg <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_rstart <= 1'b0;
            ovf         <= 1'b0;
            addr_reg    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= pwdata[0];
                ctrl_rstart <= pwdata[2];
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (wr_status && pwdata[3]) begin
                ovf <= 1'b0;
            end
            if (wr_addr) begin
                addr_reg <= pwdata[7:0];
            end
        end
    end

    // Fresh receive data wins over a read that would otherwise clear the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg <= '0;
            rx_flag     <= 1'b0;
        end else if (i2c_rx_valid) begin
            rx_data_reg <= i2c_rx_data;
            rx_flag     <= 1'b1;
        end else if (rd_rxdata) begin
            rx_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_req && pwdata[0] && !flush_req && !fifo_empty) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                if (i2c_done) begin
                    state_next = (ctrl_en && count_next != '0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        i2c_enable         = (state == ST_XFER);
        i2c_repeated_start = (state == ST_XFER) & ctrl_rstart;
        i2c_slave_address  = addr_reg;
        i2c_data_in        = data_reg;
    end

    always_comb begin
        prdata = '0;
        if (rd_ok) begin
            case (reg_sel)
                REG_CTRL:   prdata = {28'h0, 1'b0, ctrl_rstart, 1'b0, ctrl_en};
                REG_STATUS: prdata = {16'h0, 8'(count), 3'b000, rx_flag, ovf,
                                      fifo_empty, fifo_full, state != ST_IDLE};
                REG_ADDR:   prdata = {24'h0, addr_reg};
                REG_RXDATA: prdata = {24'h0, rx_data_reg};
                default:    prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_regs.sv
// Bench for apb_i2c_regs: directed walk-through plus randomized APB/controller traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_apb_i2c_regs;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        i2c_enable;
    logic [7:0]  i2c_slave_address;
    logic [7:0]  i2c_data_in;
    logic        i2c_repeated_start;
    logic        i2c_done;
    logic [7:0]  i2c_rx_data;
    logic        i2c_rx_valid;

    always #5 clk = ~clk;

    apb_i2c_regs #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .i2c_enable(i2c_enable),
        .i2c_slave_address(i2c_slave_address),
        .i2c_data_in(i2c_data_in),
        .i2c_repeated_start(i2c_repeated_start),
        .i2c_done(i2c_done),
        .i2c_rx_data(i2c_rx_data),
        .i2c_rx_valid(i2c_rx_valid)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: a byte queue plus "loading"/"sending" flags for the handover.
    logic [7:0]  mq[$];
    logic        m_en, m_rstart, m_ovf, m_rxv;
    logic [7:0]  m_rxd, m_addr, m_data;
    logic        m_loading, m_sending;
    logic [31:0] obs_prdata;
    logic        obs_pslverr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_err(input logic w, input logic [4:0] a);
        case (a[4:2])
            3'd0, 3'd1, 3'd2: return 1'b0;
            3'd3:             return !w;
            3'd4:             return w;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a[4:2])
            3'd0: return {28'h0, 1'b0, m_rstart, 1'b0, m_en};
            3'd1: return {16'h0, 8'(mq.size()), 3'b000, m_rxv, m_ovf,
                          mq.size() == 0, mq.size() == DEPTH, m_loading | m_sending};
            3'd2: return {24'h0, m_addr};
            3'd4: return {24'h0, m_rxd};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mq.delete();
        m_en = 0; m_rstart = 0; m_ovf = 0; m_rxv = 0;
        m_rxd = 0; m_addr = 0; m_data = 0;
        m_loading = 0; m_sending = 0;
    endtask

    task automatic modelStep(input logic r, s, e, w, input logic [4:0] a, input logic [31:0] d,
                             input logic dn, rv, input logic [7:0] rd);
        logic ok, wr, rdv, flush, start, push, old_en;
        int   idx, size_before;
        if (r) begin
            modelReset();
            return;
        end
        ok    = s & e & !m_err(w, a);
        wr    = ok & w;
        rdv   = ok & !w;
        idx   = int'(a[4:2]);
        flush = wr && idx == 0 && d[3];
        start = wr && idx == 0 && d[1];
        push  = wr && idx == 3;
        size_before = mq.size();
        old_en = m_en;
        if (m_loading) m_data = mq.pop_front();
        if (flush) mq.delete();
        else if (push) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
            else m_ovf = 1;
        end
        if (m_loading) begin
            m_loading = 0;
            m_sending = 1;
        end else if (m_sending) begin
            if (dn) begin
                m_sending = 0;
                m_loading = old_en && mq.size() > 0;
            end
        end else if (start && d[0] && !flush && size_before > 0) begin
            m_loading = 1;
        end
        if (wr && idx == 0) begin
            m_en = d[0];
            m_rstart = d[2];
        end
        if (wr && idx == 1 && d[3]) m_ovf = 0;
        if (wr && idx == 2) m_addr = d[7:0];
        if (rv) begin
            m_rxd = rd;
            m_rxv = 1;
        end else if (rdv && idx == 4) begin
            m_rxv = 0;
        end
    endtask

    // One clock cycle: drive at negedge, compare just after, advance the model at posedge.
    task automatic applyStimulus(input logic r, s, e, w, input logic [4:0] a, input logic [31:0] d,
                                 input logic dn, rv, input logic [7:0] rd);
        logic        acc, exp_err;
        logic [31:0] exp_rd;
        @(negedge clk);
        rst = r; psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
        i2c_done = dn; i2c_rx_valid = rv; i2c_rx_data = rd;
        #1;
        obs_prdata  = prdata;
        obs_pslverr = pslverr;
        if (!r) begin
            acc     = s & e;
            exp_err = acc & m_err(w, a);
            exp_rd  = (acc && !w && !exp_err) ? m_read(a) : 32'h0;
            checkOutput("prdata", prdata, exp_rd);
            checkOutput("pslverr", 32'(pslverr), 32'(exp_err));
            checkOutput("pready", 32'(pready), 32'h1);
            checkOutput("enable", 32'(i2c_enable), 32'(m_sending));
            checkOutput("rstart", 32'(i2c_repeated_start), 32'(m_sending & m_rstart));
            checkOutput("data_in", 32'(i2c_data_in), 32'(m_data));
            checkOutput("slave_addr", 32'(i2c_slave_address), 32'(m_addr));
        end
        @(posedge clk);
        modelStep(r, s, e, w, a, d, dn, rv, rd);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 5'h0, 32'h0, 0, 0, 8'h0);
    endtask

    task automatic apbWrite(input logic [4:0] a, input logic [31:0] d);
        applyStimulus(0, 1, 0, 1, a, d, 0, 0, 8'h0);
        applyStimulus(0, 1, 1, 1, a, d, 0, 0, 8'h0);
    endtask

    task automatic apbRead(input logic [4:0] a);
        applyStimulus(0, 1, 0, 0, a, 32'h0, 0, 0, 8'h0);
        applyStimulus(0, 1, 1, 0, a, 32'h0, 0, 0, 8'h0);
    endtask

    task automatic pulseDone();
        applyStimulus(0, 0, 0, 0, 5'h0, 32'h0, 1, 0, 8'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  a;
        logic        rv;
        logic [7:0]  rb;
        int          op;

        modelReset();
        applyStimulus(1, 0, 0, 0, 5'h0, 32'h0, 0, 0, 8'h0);
        applyStimulus(1, 0, 0, 0, 5'h0, 32'h0, 0, 0, 8'h0);
        #1 checkOutput("reset_enable", 32'(i2c_enable), 32'h0);
        apbRead(5'h00);
        checkOutput("reset_ctrl", obs_prdata, 32'h0);
        checkOutput("reset_pslverr", 32'(obs_pslverr), 32'h0);
        apbRead(5'h04);
        checkOutput("reset_status", obs_prdata, 32'h4);

        // Two-byte transfer with the one-cycle enable gap between bytes.
        apbWrite(5'h08, 32'hD7);
        apbWrite(5'h0C, 32'hAA);
        apbWrite(5'h0C, 32'h55);
        apbWrite(5'h00, 32'h3);
        #1 checkOutput("xfer_load_low", 32'(i2c_enable), 32'h0);
        idle(1);
        #1 checkOutput("xfer_b0_enable", 32'(i2c_enable), 32'h1);
        checkOutput("xfer_b0_data", 32'(i2c_data_in), 32'hAA);
        checkOutput("xfer_addr", 32'(i2c_slave_address), 32'hD7);
        pulseDone();
        #1 checkOutput("xfer_gap", 32'(i2c_enable), 32'h0);
        idle(1);
        #1 checkOutput("xfer_b1_enable", 32'(i2c_enable), 32'h1);
        checkOutput("xfer_b1_data", 32'(i2c_data_in), 32'h55);
        pulseDone();
        #1 checkOutput("xfer_end_enable", 32'(i2c_enable), 32'h0);
        apbRead(5'h04);
        checkOutput("xfer_end_status", obs_prdata, 32'h4);
        apbRead(5'h00);
        checkOutput("xfer_ctrl_pulse_bits", obs_prdata, 32'h1);

        // Overflow, sticky clear, flush.
        for (int i = 0; i < 9; i++) apbWrite(5'h0C, 32'(i + 8'h10));
        apbRead(5'h04);
        checkOutput("ovf_status", obs_prdata, 32'h80A);
        apbWrite(5'h04, 32'h8);
        apbRead(5'h04);
        checkOutput("ovf_cleared", obs_prdata, 32'h802);
        apbWrite(5'h00, 32'h8);
        apbRead(5'h04);
        checkOutput("flush_status", obs_prdata, 32'h4);

        // EN cleared mid-byte: the current byte finishes, nothing more goes out.
        apbWrite(5'h0C, 32'h11);
        apbWrite(5'h0C, 32'h22);
        apbWrite(5'h0C, 32'h33);
        apbWrite(5'h00, 32'h7);
        idle(1);
        #1 checkOutput("en_clr_rstart", 32'(i2c_repeated_start), 32'h1);
        apbWrite(5'h00, 32'h0);
        #1 checkOutput("en_clr_still_on", 32'(i2c_enable), 32'h1);
        pulseDone();
        idle(2);
        #1 checkOutput("en_clr_stopped", 32'(i2c_enable), 32'h0);
        checkOutput("en_clr_data_kept", 32'(i2c_data_in), 32'h11);
        apbRead(5'h04);
        checkOutput("en_clr_status", obs_prdata, 32'h200);

        // Receive path and error responses.
        applyStimulus(0, 0, 0, 0, 5'h0, 32'h0, 0, 1, 8'h3C);
        apbRead(5'h04);
        checkOutput("rx_status_set", obs_prdata, 32'h210);
        apbRead(5'h10);
        checkOutput("rx_data", obs_prdata, 32'h3C);
        apbRead(5'h04);
        checkOutput("rx_status_clr", obs_prdata, 32'h200);
        applyStimulus(0, 1, 0, 0, 5'h10, 32'h0, 0, 0, 8'h0);
        applyStimulus(0, 1, 1, 0, 5'h10, 32'h0, 0, 1, 8'h5A);
        apbRead(5'h04);
        checkOutput("rx_collide_flag", obs_prdata, 32'h210);
        apbRead(5'h14);
        checkOutput("unmapped_err", 32'(obs_pslverr), 32'h1);
        checkOutput("unmapped_data", obs_prdata, 32'h0);
        apbRead(5'h0C);
        checkOutput("txdata_read_err", 32'(obs_pslverr), 32'h1);
        apbWrite(5'h10, 32'hFF);
        checkOutput("rxdata_write_err", 32'(obs_pslverr), 32'h1);

        // Reset in the middle of a byte.
        apbWrite(5'h00, 32'h8);
        apbWrite(5'h0C, 32'h81);
        apbWrite(5'h0C, 32'h82);
        apbWrite(5'h00, 32'h3);
        idle(1);
        applyStimulus(1, 0, 0, 0, 5'h0, 32'h0, 0, 0, 8'h0);
        #1 checkOutput("rst_mid_enable", 32'(i2c_enable), 32'h0);
        pulseDone();
        #1 checkOutput("rst_late_done", 32'(i2c_enable), 32'h0);
        apbRead(5'h04);
        checkOutput("rst_mid_status", obs_prdata, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 99);
            rv = ($urandom_range(0, 9) == 0);
            rb = 8'($urandom);
            if (op < 25) begin
                a = 5'h0C; d = $urandom;
            end else if (op < 37) begin
                d = $urandom & 32'hFFFF_FFF4;
                d[0] = ($urandom_range(0, 9) < 8);
                d[1] = ($urandom_range(0, 1) == 1);
                d[3] = ($urandom_range(0, 11) == 0);
                a = 5'h00;
            end else if (op < 42) begin
                a = 5'h04; d = $urandom;
            end else if (op < 46) begin
                a = 5'h08; d = $urandom;
            end else if (op < 50) begin
                a = 5'($urandom); d = $urandom & 32'hFFFF_FFF7;
            end else if (op < 66) begin
                a = 5'($urandom); d = 32'h0;
            end
            if (op < 50) begin
                applyStimulus(0, 1, 0, 1, a, d, 0, rv, rb);
                applyStimulus(0, 1, 1, 1, a, d, 0, 0, rb);
            end else if (op < 66) begin
                applyStimulus(0, 1, 0, 0, a, d, 0, rv, rb);
                applyStimulus(0, 1, 1, 0, a, d, 0, 0, rb);
            end else if (op < 90) begin
                applyStimulus(0, 0, 0, 0, 5'h0, 32'h0, 1, rv, rb);
            end else if (op < 99) begin
                applyStimulus(0, 0, 0, 0, 5'h0, 32'h0, 0, rv, rb);
            end else begin
                applyStimulus(1, 0, 0, 0, 5'h0, 32'h0, 0, 0, rb);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
